// File: rtl/fp_pkg.sv
// fp_pkg: shared FP multiplier types, default field widths and constants.
// Holds the operand class enum, exponent bias helper and canonical NaN.
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    // Canonical quiet NaN for the default 32-bit format.
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_cls_e;

    function automatic int fp_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    // Canonical quiet NaN for any format: exp all-ones, mantissa MSB set.
    function automatic logic [63:0] fp_qnan(input int ew, input int mw);
        logic [63:0] v;
        v = ((64'd1 << ew) - 64'd1) << mw;
        v = v | (64'd1 << (mw - 1));
        return v;
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// fp_unpack: split an FP word into sign/exponent/significand and classify.
// Denormals classify as zero; the hidden bit is set only for normals.
module fp_unpack
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic [EXP_W+MAN_W:0] i_op,
    output logic                 o_sign,
    output logic [EXP_W-1:0]     o_exp,
    output logic [MAN_W:0]       o_man,
    output fp_cls_e              o_cls
);

    logic [MAN_W-1:0] w_frac;

    assign o_sign = i_op[EXP_W+MAN_W];
    assign o_exp  = i_op[MAN_W +: EXP_W];
    assign w_frac = i_op[MAN_W-1:0];

    // Classify from the exponent field, then the fraction for all-ones.
    always_comb begin
        o_cls = CLS_NORM;
        if (o_exp == '0)
            o_cls = CLS_ZERO;
        else if (&o_exp)
            o_cls = (w_frac == '0) ? CLS_INF : CLS_NAN;
    end

    assign o_man = {(o_cls == CLS_NORM), w_frac};

endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage FP multiplier (unpack / multiply / round+pack).
// Define FP_MUL_FLAGS_EN to add the {invalid,overflow,underflow,inexact} port.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result
`ifdef FP_MUL_FLAGS_EN
    ,
    output logic [3:0]   flags
`endif
);

    localparam int EW2 = EXP_W + 2;
    localparam int PW  = 2 * MAN_W + 2;
    localparam logic signed [EW2-1:0] BIAS = EW2'(fp_bias(EXP_W));
    localparam logic signed [EW2-1:0] EMAX = EW2'((1 << EXP_W) - 1);
    localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [EXP_W-1:0] EONES = '1;

    logic                  w_adv;
    logic                  w_sa, w_sb;
    logic [EXP_W-1:0]      w_ea, w_eb;
    logic [MAN_W:0]        w_ma, w_mb;
    fp_cls_e               w_ca, w_cb;
    logic                  w_nan, w_inf, w_zero, w_sign;
    logic [W-1:0]          w_spec_res;
    logic signed [EW2-1:0] w_esum;

    logic                  r1_valid, r1_sign, r1_spec;
    logic signed [EW2-1:0] r1_exp;
    logic [MAN_W:0]        r1_ma, r1_mb;
    logic [W-1:0]          r1_spec_res;

    logic                  r2_valid, r2_sign, r2_spec;
    logic signed [EW2-1:0] r2_exp;
    logic [PW-1:0]         r2_prod;
    logic [W-1:0]          r2_spec_res;

    logic                  w_top, w_guard, w_sticky, w_up;
    logic [PW-2:0]         w_norm;
    logic [MAN_W-1:0]      w_mant;
    logic [MAN_W:0]        w_rnd;
    logic signed [EW2-1:0] w_efin;
    logic [W-1:0]          w_res;

    logic                  r_out_valid;
    logic [W-1:0]          r_result;

`ifdef FP_MUL_FLAGS_EN
    logic [3:0] r1_flags, r2_flags, r_flags, w_flg;
`endif

    assign w_adv     = !r_out_valid || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign result    = r_result;
`ifdef FP_MUL_FLAGS_EN
    assign flags     = r_flags;
`endif

    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .i_op(a), .o_sign(w_sa), .o_exp(w_ea), .o_man(w_ma), .o_cls(w_ca)
    );

    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .i_op(b), .o_sign(w_sb), .o_exp(w_eb), .o_man(w_mb), .o_cls(w_cb)
    );

    assign w_sign = w_sa ^ w_sb;
    assign w_nan  = (w_ca == CLS_NAN) || (w_cb == CLS_NAN)
                 || (w_ca == CLS_INF && w_cb == CLS_ZERO)
                 || (w_ca == CLS_ZERO && w_cb == CLS_INF);
    assign w_inf  = (w_ca == CLS_INF) || (w_cb == CLS_INF);
    assign w_zero = (w_ca == CLS_ZERO) || (w_cb == CLS_ZERO);
    assign w_esum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS;

    // Special operand combinations resolve fully in S1; NaN beats Inf beats zero.
    always_comb begin
        w_spec_res = {w_sign, {(W-1){1'b0}}};
        if (w_nan)
            w_spec_res = QNAN;
        else if (w_inf)
            w_spec_res = {w_sign, EONES, {MAN_W{1'b0}}};
    end

    // S1: register unpacked operands, biased exponent sum and special result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid    <= 1'b0;
            r1_sign     <= 1'b0;
            r1_spec     <= 1'b0;
            r1_exp      <= '0;
            r1_ma       <= '0;
            r1_mb       <= '0;
            r1_spec_res <= '0;
        end else if (w_adv) begin
            r1_valid    <= in_valid;
            r1_sign     <= w_sign;
            r1_spec     <= w_nan || w_inf || w_zero;
            r1_exp      <= w_esum;
            r1_ma       <= w_ma;
            r1_mb       <= w_mb;
            r1_spec_res <= w_spec_res;
        end
    end

    // S2: full significand product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid    <= 1'b0;
            r2_sign     <= 1'b0;
            r2_spec     <= 1'b0;
            r2_exp      <= '0;
            r2_prod     <= '0;
            r2_spec_res <= '0;
        end else if (w_adv) begin
            r2_valid    <= r1_valid;
            r2_sign     <= r1_sign;
            r2_spec     <= r1_spec;
            r2_exp      <= r1_exp;
            r2_prod     <= PW'(r1_ma) * PW'(r1_mb);
            r2_spec_res <= r1_spec_res;
        end
    end

    // Normalise the [1,4) product so the leading one drops off the top.
    assign w_top    = r2_prod[PW-1];
    assign w_norm   = w_top ? r2_prod[PW-2:0] : {r2_prod[PW-3:0], 1'b0};
    assign w_mant   = w_norm[PW-2 -: MAN_W];
    assign w_guard  = w_norm[MAN_W];
    assign w_sticky = |w_norm[MAN_W-1:0];
    assign w_up     = w_guard && (w_sticky || w_mant[0]);
    assign w_rnd    = {1'b0, w_mant} + (MAN_W+1)'(w_up);
    assign w_efin   = r2_exp + EW2'(w_top) + EW2'(w_rnd[MAN_W]);

    // S3 combinational: pick special, overflow, flush-to-zero or rounded result.
    always_comb begin
        w_res = {r2_sign, {(W-1){1'b0}}};
`ifdef FP_MUL_FLAGS_EN
        w_flg = 4'b0000;
`endif
        if (r2_spec) begin
            w_res = r2_spec_res;
`ifdef FP_MUL_FLAGS_EN
            w_flg = r2_flags;
`endif
        end else if (w_efin >= EMAX) begin
            w_res = {r2_sign, EONES, {MAN_W{1'b0}}};
`ifdef FP_MUL_FLAGS_EN
            w_flg = 4'b0101;
`endif
        end else if (w_efin <= 0) begin
            w_res = {r2_sign, {(W-1){1'b0}}};
`ifdef FP_MUL_FLAGS_EN
            w_flg = 4'b0010;
`endif
        end else begin
            w_res = {r2_sign, w_efin[EXP_W-1:0], w_rnd[MAN_W-1:0]};
`ifdef FP_MUL_FLAGS_EN
            w_flg = {3'b000, w_guard || w_sticky};
`endif
        end
    end

    // S3: output register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else if (w_adv) begin
            r_out_valid <= r2_valid;
            r_result    <= w_res;
        end
    end

`ifdef FP_MUL_FLAGS_EN
    // Flag pipeline: invalid is known in S1, the rest come from S3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_flags <= '0;
            r2_flags <= '0;
            r_flags  <= '0;
        end else if (w_adv) begin
            r1_flags <= {w_nan, 3'b000};
            r2_flags <= r1_flags;
            r_flags  <= w_flg;
        end
    end
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed scoreboard bench for fp_mul_pipe.
// Flags are compared only when FP_MUL_FLAGS_EN is defined.
module tb_fp_mul_pipe;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic        out_valid, out_ready;
    logic [31:0] a, b, result;
`ifdef FP_MUL_FLAGS_EN
    logic [3:0]  flags;
`endif

    int          checks = 0;
    int          errors = 0;
    int          nres = 0;
    int          n0;
    logic [35:0] sb[$];
    logic        held;
    logic [31:0] held_res;

    always #5 clk = ~clk;

    fp_mul_pipe dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result)
`ifdef FP_MUL_FLAGS_EN
        ,
        .flags(flags)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [35:0] e);
        check({tag, "_res"}, result, e[35:4]);
`ifdef FP_MUL_FLAGS_EN
        check({tag, "_flg"}, {28'd0, flags}, {28'd0, e[3:0]});
`endif
    endtask

    // Drive one operand pair at posedge+1; push the expectation on acceptance.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb2,
                        input logic [31:0] er, input logic [3:0] ef);
        a = ta;
        b = tb2;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({er, ef});
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("drain_left", sb.size(), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        held = 1'b0;
        held_res = '0;

        // Output monitor: pop and compare on every output transfer.
        fork
            forever begin
                logic [35:0] e;
                @(negedge clk);
                if (rst_n && out_valid) begin
                    if (held) check("hold_res", result, held_res);
                    if (!out_ready) begin
                        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                        held = 1'b1;
                        held_res = result;
                    end else begin
                        held = 1'b0;
                        if (sb.size() == 0) begin
                            check("unexpected_out", result, 32'hxxxx_xxxx);
                        end else begin
                            e = sb.pop_front();
                            check_out("out", e);
                            nres++;
                        end
                    end
                end else begin
                    held = 1'b0;
                end
            end
        join_none

        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_result", result, 32'd0);
`ifdef FP_MUL_FLAGS_EN
        check("rst_flags", {28'd0, flags}, 32'd0);
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Latency: 1.5 x 2.0 visible three cycles after it was presented.
        send(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
        check("lat_c1", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_c2", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_c3", {31'd0, out_valid}, 32'd1);
        check("lat_res", result, 32'h40400000);
        idle(2);

        // Directed corner cases, back to back.
        send(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
        send(32'h7F800000, 32'h00000000, FP_QNAN, 4'b1000);
        send(32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
        send(32'h00800000, 32'h00800000, 32'h00000000, 4'b0010);
        send(32'h80800000, 32'h00800000, 32'h80000000, 4'b0010);
        send(32'hBFC00000, 32'h40000000, 32'hC0400000, 4'b0000);
        send(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
        send(32'hFF800000, 32'hFF800000, 32'h7F800000, 4'b0000);
        send(32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000);
        send(32'h7FC12345, 32'h3F800000, FP_QNAN, 4'b1000);
        send(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000);
        send(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001);
        send(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001);
        drain();

        // Six back-to-back inputs with the consumer stalled in cycles 4-8.
        n0 = nres;
        fork
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join_none
        send(32'h3F800000, 32'h40000000, 32'h40000000, 4'b0000);
        send(32'h40000000, 32'h40000000, 32'h40800000, 4'b0000);
        send(32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000);
        send(32'h40800000, 32'h40000000, 32'h41000000, 4'b0000);
        send(32'h3F000000, 32'h40000000, 32'h3F800000, 4'b0000);
        send(32'h41200000, 32'h40000000, 32'h41A00000, 4'b0000);
        drain();
        check("b2b_count", nres - n0, 32'd6);

        // Reset with two operations in flight and the output stalled.
        idle(2);
        out_ready = 1'b0;
        send(32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000);
        send(32'h40400000, 32'h40400000, 32'h41100000, 4'b0000);
        idle(3);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(6);
        check("post_rst_quiet", {31'd0, out_valid}, 32'd0);
        send(32'h40000000, 32'h40000000, 32'h40800000, 4'b0000);
        drain();
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
